alu_issue_sched: RTL and testbench

- Reservation-station scheduler that feeds the single-cycle ALU functional unit.
- Buffers up to RS_DEPTH dispatched ALU micro-ops and captures missing source operands from the CDB broadcast (wakeup).
- Each cycle, selects the oldest entry with both operands ready and drives the ALU's exe_v/opcode/operand/dest inputs through a registered issue stage.

---
 rtl/alu_issue_sched_pkg.sv | 53 +++++
 rtl/alu_issue_sched_select.sv | 29 ++
 rtl/alu_issue_sched.sv | 167 ++++++++++++++++
 tb/tb_alu_issue_sched.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_sched_pkg
// Description : Shared widths, scheduler entry and ALU issue bundle types,
//               and the CDB tag-match helper used by wakeup and bypass.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_issue_sched_pkg;

    localparam int C_RS_DEPTH     = 4;
    localparam int C_WORD_SIZE    = 16;
    localparam int C_WIDTH_OP     = 4;
    localparam int C_ROB_ENTRY    = 16;
    localparam int C_NUM_PHYS_REG = 32;
    localparam int C_TAG_W        = $clog2(C_NUM_PHYS_REG);
    localparam int C_ROB_W        = $clog2(C_ROB_ENTRY);

    // One reservation-station slot
    typedef struct packed {
        logic                   valid;
        logic [C_WIDTH_OP-1:0]  opcode;
        logic [C_TAG_W-1:0]     src1_tag;
        logic                   src1_rdy;
        logic [C_WORD_SIZE-1:0] src1_val;
        logic [C_TAG_W-1:0]     src2_tag;
        logic                   src2_rdy;
        logic [C_WORD_SIZE-1:0] src2_val;
        logic [C_ROB_W-1:0]     rob;
        logic [C_TAG_W-1:0]     dst_reg;
    } rs_entry_t;

    // Input bundle of the single-cycle ALU
    typedef struct packed {
        logic                   exe_v;
        logic [C_WIDTH_OP-1:0]  opcode;
        logic [C_WORD_SIZE-1:0] op1;
        logic [C_WORD_SIZE-1:0] op2;
        logic [C_ROB_W-1:0]     rob;
        logic [C_TAG_W-1:0]     dst_reg;
    } alu_issue_t;

    // A source captures the broadcast only while it is still waiting
    function automatic logic cdb_match(
        input logic               rdy,
        input logic [C_TAG_W-1:0] tag,
        input logic               cdb_v,
        input logic [C_TAG_W-1:0] cdb_tag
    );
        return !rdy && cdb_v && (tag == cdb_tag);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_sched_select.sv
`default_nettype none
// ============================================================================
// Module      : alu_sched_select
// Description : Oldest-ready priority encoder; index 0 is the oldest entry.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sched_select #(
    parameter int RS_DEPTH = 4,
    parameter int IDX_W    = 2
) (
    input  logic [RS_DEPTH-1:0] i_ready,
    output logic                o_sel_v,
    output logic [IDX_W-1:0]    o_sel_idx
);

    // Scan from youngest to oldest so the lowest ready index wins
    always_comb begin
        o_sel_v   = 1'b0;
        o_sel_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (i_ready[i]) begin
                o_sel_v   = 1'b1;
                o_sel_idx = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue_sched.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_sched
// Description : Compacting-age-queue reservation station for the ALU.
//               Captures operands from the CDB, selects the oldest ready
//               entry and drives the ALU through a registered issue stage.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_sched
    import alu_issue_sched_pkg::*;
#(
    parameter int RS_DEPTH     = C_RS_DEPTH,
    parameter int WORD_SIZE_P  = C_WORD_SIZE,
    parameter int WIDTH_OP     = C_WIDTH_OP,
    parameter int ROB_ENTRY    = C_ROB_ENTRY,
    parameter int NUM_PHYS_REG = C_NUM_PHYS_REG
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic                            flush_i,
    input  logic                            disp_v_i,
    output logic                            disp_ready_o,
    input  logic [WIDTH_OP-1:0]             disp_opcode_i,
    input  logic [$clog2(NUM_PHYS_REG)-1:0] disp_src1_tag_i,
    input  logic [$clog2(NUM_PHYS_REG)-1:0] disp_src2_tag_i,
    input  logic                            disp_src1_rdy_i,
    input  logic                            disp_src2_rdy_i,
    input  logic [WORD_SIZE_P-1:0]          disp_src1_val_i,
    input  logic [WORD_SIZE_P-1:0]          disp_src2_val_i,
    input  logic [$clog2(ROB_ENTRY)-1:0]    disp_rob_i,
    input  logic [$clog2(NUM_PHYS_REG)-1:0] disp_reg_i,
    input  logic                            cdb_v_i,
    input  logic [$clog2(NUM_PHYS_REG)-1:0] cdb_tag_i,
    input  logic [WORD_SIZE_P-1:0]          cdb_result_i,
    output logic                            iss_v_o,
    output logic [WIDTH_OP-1:0]             iss_opcode_o,
    output logic [WORD_SIZE_P-1:0]          iss_op1_o,
    output logic [WORD_SIZE_P-1:0]          iss_op2_o,
    output logic [$clog2(ROB_ENTRY)-1:0]    iss_rob_o,
    output logic [$clog2(NUM_PHYS_REG)-1:0] iss_reg_o,
    output logic [$clog2(RS_DEPTH+1)-1:0]   count_o
);

    localparam int C_IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
    localparam int C_CNT_W = $clog2(RS_DEPTH + 1);

    rs_entry_t            r_rs   [RS_DEPTH];
    rs_entry_t            w_woke [RS_DEPTH];
    rs_entry_t            w_next [RS_DEPTH];
    rs_entry_t            w_disp_ent;
    alu_issue_t           r_iss;
    logic [C_CNT_W-1:0]   r_count;
    logic [C_CNT_W-1:0]   w_wr_idx;
    logic [RS_DEPTH-1:0]  w_ready;
    logic                 w_sel_v;
    logic [C_IDX_W-1:0]   w_sel_idx;
    logic                 w_disp_acc;

    // Ready reflects registered credit only; an issue this cycle frees nothing yet
    assign disp_ready_o = (r_count < C_CNT_W'(RS_DEPTH));
    assign w_disp_acc   = disp_v_i && disp_ready_o && !flush_i;
    assign count_o      = r_count;

    // Eligibility uses registered ready bits, so a wakeup counts next cycle
    for (genvar g = 0; g < RS_DEPTH; g++) begin : g_ready
        assign w_ready[g] = r_rs[g].valid & r_rs[g].src1_rdy & r_rs[g].src2_rdy;
    end

    alu_sched_select #(
        .RS_DEPTH (RS_DEPTH),
        .IDX_W    (C_IDX_W)
    ) u_select (
        .i_ready   (w_ready),
        .o_sel_v   (w_sel_v),
        .o_sel_idx (w_sel_idx)
    );

    // Build the incoming entry, capturing a same-cycle CDB broadcast
    always_comb begin
        w_disp_ent          = '0;
        w_disp_ent.valid    = 1'b1;
        w_disp_ent.opcode   = disp_opcode_i;
        w_disp_ent.src1_tag = disp_src1_tag_i;
        w_disp_ent.src2_tag = disp_src2_tag_i;
        w_disp_ent.rob      = disp_rob_i;
        w_disp_ent.dst_reg  = disp_reg_i;
        w_disp_ent.src1_rdy = disp_src1_rdy_i;
        w_disp_ent.src1_val = disp_src1_val_i;
        w_disp_ent.src2_rdy = disp_src2_rdy_i;
        w_disp_ent.src2_val = disp_src2_val_i;
        if (cdb_match(disp_src1_rdy_i, disp_src1_tag_i, cdb_v_i, cdb_tag_i)) begin
            w_disp_ent.src1_rdy = 1'b1;
            w_disp_ent.src1_val = cdb_result_i;
        end
        if (cdb_match(disp_src2_rdy_i, disp_src2_tag_i, cdb_v_i, cdb_tag_i)) begin
            w_disp_ent.src2_rdy = 1'b1;
            w_disp_ent.src2_val = cdb_result_i;
        end
    end

    // Next queue image: wakeup, then compaction over the issued slot, then append
    always_comb begin
        w_wr_idx = r_count - C_CNT_W'(w_sel_v);
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_woke[i] = r_rs[i];
            if (r_rs[i].valid && cdb_match(r_rs[i].src1_rdy, r_rs[i].src1_tag, cdb_v_i, cdb_tag_i)) begin
                w_woke[i].src1_rdy = 1'b1;
                w_woke[i].src1_val = cdb_result_i;
            end
            if (r_rs[i].valid && cdb_match(r_rs[i].src2_rdy, r_rs[i].src2_tag, cdb_v_i, cdb_tag_i)) begin
                w_woke[i].src2_rdy = 1'b1;
                w_woke[i].src2_val = cdb_result_i;
            end
        end
        for (int i = 0; i < RS_DEPTH - 1; i++) begin
            w_next[i] = (w_sel_v && (C_IDX_W'(i) >= w_sel_idx)) ? w_woke[i+1] : w_woke[i];
        end
        // Any issue vacates the top slot of a contiguous queue
        w_next[RS_DEPTH-1] = w_sel_v ? '0 : w_woke[RS_DEPTH-1];
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (w_disp_acc && (C_CNT_W'(i) == w_wr_idx)) begin
                w_next[i] = w_disp_ent;
            end
        end
    end

    // Entry storage and occupancy; flush discards everything in flight
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < RS_DEPTH; i++) r_rs[i] <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < RS_DEPTH; i++) r_rs[i] <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) r_rs[i] <= w_next[i];
            r_count <= r_count + C_CNT_W'(w_disp_acc) - C_CNT_W'(w_sel_v);
        end
    end

    // Registered issue stage; payload holds its last value when idle
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_iss <= '0;
        end else if (flush_i) begin
            r_iss.exe_v <= 1'b0;
        end else begin
            r_iss.exe_v <= w_sel_v;
            if (w_sel_v) begin
                r_iss.opcode  <= r_rs[w_sel_idx].opcode;
                r_iss.op1     <= r_rs[w_sel_idx].src1_val;
                r_iss.op2     <= r_rs[w_sel_idx].src2_val;
                r_iss.rob     <= r_rs[w_sel_idx].rob;
                r_iss.dst_reg <= r_rs[w_sel_idx].dst_reg;
            end
        end
    end

    assign iss_v_o      = r_iss.exe_v;
    assign iss_opcode_o = r_iss.opcode;
    assign iss_op1_o    = r_iss.op1;
    assign iss_op2_o    = r_iss.op2;
    assign iss_rob_o    = r_iss.rob;
    assign iss_reg_o    = r_iss.dst_reg;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_sched
// Description : Self-checking bench for alu_issue_sched with a queue-based
//               reference model, directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_sched;

    localparam int RS_DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        flush_i;
    logic        disp_v_i;
    logic        disp_ready_o;
    logic [3:0]  disp_opcode_i;
    logic [4:0]  disp_src1_tag_i, disp_src2_tag_i;
    logic        disp_src1_rdy_i, disp_src2_rdy_i;
    logic [15:0] disp_src1_val_i, disp_src2_val_i;
    logic [3:0]  disp_rob_i;
    logic [4:0]  disp_reg_i;
    logic        cdb_v_i;
    logic [4:0]  cdb_tag_i;
    logic [15:0] cdb_result_i;
    logic        iss_v_o;
    logic [3:0]  iss_opcode_o;
    logic [15:0] iss_op1_o, iss_op2_o;
    logic [3:0]  iss_rob_o;
    logic [4:0]  iss_reg_o;
    logic [2:0]  count_o;

    always #5 clk_i = ~clk_i;

    alu_issue_sched dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .flush_i(flush_i),
        .disp_v_i(disp_v_i), .disp_ready_o(disp_ready_o), .disp_opcode_i(disp_opcode_i),
        .disp_src1_tag_i(disp_src1_tag_i), .disp_src2_tag_i(disp_src2_tag_i),
        .disp_src1_rdy_i(disp_src1_rdy_i), .disp_src2_rdy_i(disp_src2_rdy_i),
        .disp_src1_val_i(disp_src1_val_i), .disp_src2_val_i(disp_src2_val_i),
        .disp_rob_i(disp_rob_i), .disp_reg_i(disp_reg_i),
        .cdb_v_i(cdb_v_i), .cdb_tag_i(cdb_tag_i), .cdb_result_i(cdb_result_i),
        .iss_v_o(iss_v_o), .iss_opcode_o(iss_opcode_o), .iss_op1_o(iss_op1_o),
        .iss_op2_o(iss_op2_o), .iss_rob_o(iss_rob_o), .iss_reg_o(iss_reg_o),
        .count_o(count_o)
    );

    // Reference model: an ordered list of pending micro-ops, oldest first
    typedef struct {
        logic [3:0]  op;
        logic [4:0]  t1, t2;
        bit          r1, r2;
        logic [15:0] v1, v2;
        logic [3:0]  rob;
        logic [4:0]  rg;
    } m_ent_t;

    m_ent_t      m_q[$];
    bit          e_v;
    logic [3:0]  e_op;
    logic [15:0] e_op1, e_op2;
    logic [3:0]  e_rob;
    logic [4:0]  e_reg;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic check_outputs();
        check("count", 32'(count_o), 32'(m_q.size()));
        check("disp_ready", 32'(disp_ready_o), 32'(m_q.size() < RS_DEPTH));
        check("iss_v", 32'(iss_v_o), 32'(e_v));
        if (e_v) begin
            check("iss_opcode", 32'(iss_opcode_o), 32'(e_op));
            check("iss_op1", 32'(iss_op1_o), 32'(e_op1));
            check("iss_op2", 32'(iss_op2_o), 32'(e_op2));
            check("iss_rob", 32'(iss_rob_o), 32'(e_rob));
            check("iss_reg", 32'(iss_reg_o), 32'(e_reg));
        end
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        int     sel;
        bit     can_take;
        m_ent_t e;
        sel = -1;
        if (flush_i) begin
            e_v = 1'b0;
            m_q.delete();
            return;
        end
        can_take = (m_q.size() < RS_DEPTH);
        for (int i = 0; i < m_q.size(); i++) begin
            if (m_q[i].r1 && m_q[i].r2) begin
                sel = i;
                break;
            end
        end
        e_v = (sel >= 0);
        if (sel >= 0) begin
            e_op = m_q[sel].op; e_op1 = m_q[sel].v1; e_op2 = m_q[sel].v2;
            e_rob = m_q[sel].rob; e_reg = m_q[sel].rg;
        end
        for (int i = 0; i < m_q.size(); i++) begin
            e = m_q[i];
            if (cdb_v_i && !e.r1 && e.t1 == cdb_tag_i) begin e.r1 = 1'b1; e.v1 = cdb_result_i; end
            if (cdb_v_i && !e.r2 && e.t2 == cdb_tag_i) begin e.r2 = 1'b1; e.v2 = cdb_result_i; end
            m_q[i] = e;
        end
        if (sel >= 0) m_q.delete(sel);
        if (disp_v_i && can_take) begin
            e.op = disp_opcode_i; e.rob = disp_rob_i; e.rg = disp_reg_i;
            e.t1 = disp_src1_tag_i; e.r1 = disp_src1_rdy_i; e.v1 = disp_src1_val_i;
            e.t2 = disp_src2_tag_i; e.r2 = disp_src2_rdy_i; e.v2 = disp_src2_val_i;
            if (cdb_v_i && !e.r1 && e.t1 == cdb_tag_i) begin e.r1 = 1'b1; e.v1 = cdb_result_i; end
            if (cdb_v_i && !e.r2 && e.t2 == cdb_tag_i) begin e.r2 = 1'b1; e.v2 = cdb_result_i; end
            m_q.push_back(e);
        end
    endtask

    task automatic step();
        check_outputs();
        model_step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        flush_i = 1'b0; disp_v_i = 1'b0; cdb_v_i = 1'b0;
    endtask

    task automatic set_disp(input logic [3:0] op,
                            input logic [4:0] t1, input logic r1, input logic [15:0] v1,
                            input logic [4:0] t2, input logic r2, input logic [15:0] v2,
                            input logic [3:0] rob, input logic [4:0] rg);
        disp_v_i = 1'b1; disp_opcode_i = op;
        disp_src1_tag_i = t1; disp_src1_rdy_i = r1; disp_src1_val_i = v1;
        disp_src2_tag_i = t2; disp_src2_rdy_i = r2; disp_src2_val_i = v2;
        disp_rob_i = rob; disp_reg_i = rg;
    endtask

    task automatic set_cdb(input logic [4:0] tag, input logic [15:0] val);
        cdb_v_i = 1'b1; cdb_tag_i = tag; cdb_result_i = val;
    endtask

    initial begin
        reset_n_i = 1'b0;
        idle();
        set_disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
        disp_v_i = 1'b0;
        cdb_tag_i = '0; cdb_result_i = '0;
        e_v = 1'b0; e_op = '0; e_op1 = '0; e_op2 = '0; e_rob = '0; e_reg = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_iss_v", 32'(iss_v_o), 32'd0);
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_op1", 32'(iss_op1_o), 32'd0);
        check("rst_op2", 32'(iss_op2_o), 32'd0);
        check("rst_rob_reg_op", {iss_opcode_o, iss_rob_o, iss_reg_o}, 32'd0);
        reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Single ready ADD: visible two cycles after dispatch
        set_disp(4'h1, 0, 1, 16'd5, 0, 1, 16'd3, 4'd2, 5'd7);
        step(); idle(); repeat (3) step();

        // Older op waits on tag 9 while a younger ready op overtakes it
        set_disp(4'h2, 5'd9, 0, 16'h0, 5'd1, 1, 16'h0011, 4'd3, 5'd8);
        step();
        set_disp(4'h3, 5'd2, 1, 16'd10, 5'd3, 1, 16'd20, 4'd4, 5'd9);
        step(); idle(); step();
        set_cdb(5'd9, 16'h00FF);
        step(); idle(); repeat (4) step();

        // Dispatch-cycle bypass of src2 from the CDB
        set_disp(4'h4, 5'd5, 1, 16'd7, 5'd4, 0, 16'hDEAD, 4'd5, 5'd10);
        set_cdb(5'd4, 16'h1234);
        step(); idle(); repeat (3) step();

        // Fill with waiting entries, reject a fifth, then wake the third
        for (int k = 0; k < 4; k++) begin
            set_disp(4'(k), 5'(20 + k), 0, 16'h0, 5'd1, 1, 16'(k), 4'(k), 5'(k));
            step();
        end
        set_disp(4'hF, 5'd1, 1, 16'h7777, 5'd1, 1, 16'h8888, 4'hF, 5'd31);
        step(); idle(); step();
        set_cdb(5'd22, 16'hABCD);
        step(); idle(); repeat (3) step();
        flush_i = 1'b1;
        step(); idle(); step();

        // Three ready entries, then flush with a concurrent dispatch
        for (int k = 0; k < 3; k++) begin
            set_disp(4'h6, 5'd25, 0, 16'h0, 5'd1, 1, 16'(100 + k), 4'(8 + k), 5'(12 + k));
            step();
        end
        idle();
        set_cdb(5'd25, 16'h0055);
        step();
        idle();
        flush_i = 1'b1;
        set_disp(4'h9, 5'd1, 1, 16'h4242, 5'd1, 1, 16'h2424, 4'd1, 5'd1);
        step(); idle(); repeat (3) step();

        // Random traffic with a small tag space so wakeups occur often
        for (int n = 0; n < 400; n++) begin
            set_disp(4'($urandom), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 16'($urandom),
                     5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 16'($urandom),
                     4'($urandom), 5'($urandom));
            disp_v_i     = ($urandom_range(0, 9) < 6);
            cdb_v_i      = 1'($urandom_range(0, 1));
            cdb_tag_i    = 5'($urandom_range(0, 7));
            cdb_result_i = 16'($urandom);
            flush_i      = ($urandom_range(0, 49) == 0);
            step();
        end
        idle();
        flush_i = 1'b1;
        step(); idle();

        // Asynchronous reset in the middle of a stream of issues
        for (int k = 0; k < 3; k++) begin
            set_disp(4'h5, 5'd1, 1, 16'(200 + k), 5'd1, 1, 16'(300 + k), 4'(k), 5'(k));
            step();
        end
        idle();
        check_outputs();
        #3;
        reset_n_i = 1'b0;
        #1;
        check("async_rst_iss_v", 32'(iss_v_o), 32'd0);
        check("async_rst_count", 32'(count_o), 32'd0);
        m_q.delete();
        e_v = 1'b0;
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
